// File: rtl/pipelined_gate_delay_if.sv
// Operand and result bundle for pipelined_gate_delay. The master drives samples
// and the slave (the pipeline) returns the delayed gate outputs.
interface pipelined_gate_delay_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic             e_valid;
  logic             y_valid;
  logic             x_valid;

  modport master (
    output in_valid, A, B, C,
    input  e, y, x, e_valid, y_valid, x_valid
  );

  modport slave (
    input  in_valid, A, B, C,
    output e, y, x, e_valid, y_valid, x_valid
  );
endinterface

// File: rtl/pipelined_gate_delay.sv
// Models gate propagation delay as register pipelines: e = A & B, y = f(C),
// x = e | y, each with its own latency; ALIGN pads the paths so x sees one sample.
module pipelined_gate_delay #(
  parameter int WIDTH  = 4,
  parameter int E_LAT  = 3,
  parameter int Y_LAT  = 1,
  parameter int X_LAT  = 2,
  parameter int Y_MODE = 0,
  parameter int ALIGN  = 0
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_gate_delay_if.slave  bus
);

  localparam int MAX_LAT = (E_LAT > Y_LAT) ? E_LAT : Y_LAT;
  // In aligned mode both paths run to the longer latency; e is still tapped
  // at E_LAT for its own output, while the OR stage reads the padded tail.
  localparam int E_DEPTH = (ALIGN != 0) ? MAX_LAT : E_LAT;
  localparam int Y_DEPTH = (ALIGN != 0) ? MAX_LAT : Y_LAT;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } stage_t;

  stage_t e_pipe_q [E_DEPTH];
  stage_t e_pipe_d [E_DEPTH];
  stage_t y_pipe_q [Y_DEPTH];
  stage_t y_pipe_d [Y_DEPTH];
  stage_t x_pipe_q [X_LAT];
  stage_t x_pipe_d [X_LAT];

  logic [WIDTH-1:0] f_c;
  stage_t           e_tail;
  stage_t           y_tail;

  assign f_c    = (Y_MODE != 0) ? (~bus.C) + WIDTH'(1) : ~bus.C;
  assign e_tail = e_pipe_q[E_DEPTH-1];
  assign y_tail = y_pipe_q[Y_DEPTH-1];

  // NOTE: every element of each _d array is assigned on every pass, so no latch can form.
  always_comb begin
    e_pipe_d[0] = '{v: bus.in_valid, d: bus.A & bus.B};
    for (int i = 1; i < E_DEPTH; i++) e_pipe_d[i] = e_pipe_q[i-1];

    y_pipe_d[0] = '{v: bus.in_valid, d: f_c};
    for (int i = 1; i < Y_DEPTH; i++) y_pipe_d[i] = y_pipe_q[i-1];

    x_pipe_d[0] = '{v: e_tail.v & y_tail.v, d: e_tail.d | y_tail.d};
    for (int i = 1; i < X_LAT; i++) x_pipe_d[i] = x_pipe_q[i-1];
  end

  // NOTE: non-blocking updates let every stage shift from its predecessor's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay arrays are cleared too, so no pre-reset sample can drain out later.
      e_pipe_q <= '{default: '0};
      y_pipe_q <= '{default: '0};
      x_pipe_q <= '{default: '0};
    end else begin
      e_pipe_q <= e_pipe_d;
      y_pipe_q <= y_pipe_d;
      x_pipe_q <= x_pipe_d;
    end
  end

  assign bus.e       = e_pipe_q[E_LAT-1].d;
  assign bus.e_valid = e_pipe_q[E_LAT-1].v;
  assign bus.y       = y_tail.d;
  assign bus.y_valid = y_tail.v;
  assign bus.x       = x_pipe_q[X_LAT-1].d;
  assign bus.x_valid = x_pipe_q[X_LAT-1].v;

endmodule

// File: tb/tb_pipelined_gate_delay.sv
// Drives one shared random stream into many parameter variants of the pipeline
// and scoreboards every output cycle against a sample-history reference model.
module tb_pipelined_gate_delay;

  localparam int N_CFG = 21;
  localparam int HIST  = 8192;

  typedef struct {
    int         target;
    logic [4:0] e;
    logic [4:0] y;
    logic [4:0] x;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid_drv = 1'b0;
  logic [3:0] a_drv = '0;
  logic [3:0] b_drv = '0;
  logic [3:0] c_drv = '0;

  int edge_cnt = 0;
  int base     = 0;
  bit fresh    = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  logic       v_h [HIST];
  logic [3:0] a_h [HIST];
  logic [3:0] b_h [HIST];
  logic [3:0] c_h [HIST];

  event drove;
  event clr;
  event chk_rst;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic int lv(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Sample index i as seen by a register: samples from before the last reset read as zero.
  function automatic logic [4:0] ab_at(input int i);
    if (i < base) return 5'd0;
    return {v_h[i], a_h[i] & b_h[i]};
  endfunction

  function automatic logic [4:0] fc_at(input int i, input int ym);
    logic [3:0] f;
    if (i < base) return 5'd0;
    if (ym != 0) f = 4'((16 - int'(c_h[i])) % 16);
    else         f = 4'(15 - int'(c_h[i]));
    return {v_h[i], f};
  endfunction

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    rst = 1'b0;
    if (fresh) begin
      base  = edge_cnt;
      fresh = 1'b0;
    end
    in_valid_drv = v;
    a_drv = a;
    b_drv = b;
    c_drv = c;
    v_h[edge_cnt] = v;
    a_h[edge_cnt] = a;
    b_h[edge_cnt] = b;
    c_h[edge_cnt] = c;
    -> drove;
  endtask

  task automatic drive_rand(input int valid_pct);
    drive(($urandom % 100) < valid_pct, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  for (genvar g = 0; g < N_CFG; g++) begin : cfg
    localparam int I  = (g < 3) ? 0 : g - 3;
    localparam int E  = (g < 3) ? 3 : lv(I % 3);
    localparam int Y  = (g < 3) ? 1 : lv((I / 3) % 3);
    localparam int X  = (g < 3) ? 2 : lv((I + I / 3) % 3);
    localparam int YM = (g == 2) ? 1 : ((g < 3) ? 0 : I % 2);
    localparam int AL = (g == 1) ? 1 : ((g < 3) ? 0 : I / 9);
    localparam int M  = (E > Y) ? E : Y;
    localparam int YE = (AL != 0) ? M : Y;

    pipelined_gate_delay_if #(.WIDTH(4)) bus ();

    assign bus.in_valid = in_valid_drv;
    assign bus.A        = a_drv;
    assign bus.B        = b_drv;
    assign bus.C        = c_drv;

    pipelined_gate_delay #(
      .WIDTH(4), .E_LAT(E), .Y_LAT(Y), .X_LAT(X), .Y_MODE(YM), .ALIGN(AL)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    exp_t q[$];

    // x combines the AND result and f(C) from possibly different samples unless aligned.
    function automatic logic [4:0] x_model(input int t);
      logic [4:0] p;
      logic [4:0] r;
      if (AL != 0) begin
        p = ab_at(t - X - M);
        r = fc_at(t - X - M, YM);
      end else begin
        p = ab_at(t - X - E);
        r = fc_at(t - X - Y, YM);
      end
      return {p[4] & r[4], p[3:0] | r[3:0]};
    endfunction

    always @(drove) begin
      exp_t t;
      t.target = edge_cnt + 1;
      t.e      = ab_at(t.target - E);
      t.y      = fc_at(t.target - YE, YM);
      t.x      = x_model(t.target);
      q.push_back(t);
    end

    always @(clr) q.delete();

    always @(chk_rst) begin
      check($sformatf("cfg%0d rst e", g), {bus.e_valid, bus.e}, 5'd0);
      check($sformatf("cfg%0d rst y", g), {bus.y_valid, bus.y}, 5'd0);
      check($sformatf("cfg%0d rst x", g), {bus.x_valid, bus.x}, 5'd0);
    end

    always @(negedge clk) begin
      if (!rst) begin
        while (q.size() > 0 && q[0].target < edge_cnt) begin
          check($sformatf("cfg%0d order", g), q[0].target, edge_cnt);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].target == edge_cnt) begin
          check($sformatf("cfg%0d e", g), {bus.e_valid, bus.e}, q[0].e);
          check($sformatf("cfg%0d y", g), {bus.y_valid, bus.y}, q[0].y);
          check($sformatf("cfg%0d x", g), {bus.x_valid, bus.x}, q[0].x);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);

    // Steady zeros, then all-ones: exposes the x glitch when paths are misaligned.
    repeat (10) drive(1'b1, 4'h0, 4'h0, 4'h0);
    repeat (10) drive(1'b1, 4'hF, 4'hF, 4'hF);

    // Isolated valid pulse between invalid samples.
    repeat (10) drive_rand(0);
    drive(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
    repeat (12) drive_rand(0);

    // Negation corner values for C.
    drive(1'b1, 4'h5, 4'h6, 4'd3);
    drive(1'b1, 4'h9, 4'hA, 4'd0);
    drive(1'b1, 4'hC, 4'h3, 4'd8);
    repeat (10) drive_rand(100);

    repeat (300) drive_rand(75);

    // Reset asserted between edges mid-stream; inputs keep toggling while held.
    @(posedge clk);
    #2 rst = 1'b1;
    fresh = 1'b1;
    -> clr;
    #1 -> chk_rst;
    #1;
    repeat (3) begin
      @(negedge clk);
      in_valid_drv = 1'b1;
      a_drv = 4'($urandom);
      b_drv = 4'($urandom);
      c_drv = 4'($urandom);
    end

    repeat (40) drive_rand(100);
    repeat (60) drive_rand(50);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
